// File: rtl/border_crop_axis.sv
// ============================================================================
// Module   : border_crop_axis
// Purpose  : Strips a NUM_PADDING-wide halo from every AXI-Stream frame and
//            regenerates tuser/tlast for the cropped IMG_WIDTH x IMG_HEIGHT grid.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module border_crop_axis #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int IMG_WIDTH          = 640,
  parameter int IMG_HEIGHT         = 480,
  parameter int NUM_PADDING        = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            s00_axis_tvalid,
  output logic                            s00_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                            s00_axis_tlast,
  input  logic                            s00_axis_tuser,
  output logic                            m00_axis_tvalid,
  input  logic                            m00_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                            m00_axis_tlast,
  output logic                            m00_axis_tuser,
  output logic                            err_line,
  output logic                            err_sof
);

  localparam int SW = C_AXIS_TDATA_WIDTH / 8;

  localparam logic [15:0] c_PW_LAST   = 16'(IMG_WIDTH + 2 * NUM_PADDING - 1);
  localparam logic [15:0] c_PH_LAST   = 16'(IMG_HEIGHT + 2 * NUM_PADDING - 1);
  localparam logic [15:0] c_LO        = 16'(NUM_PADDING);
  localparam logic [15:0] c_COL_HI    = 16'(IMG_WIDTH + NUM_PADDING);
  localparam logic [15:0] c_ROW_HI    = 16'(IMG_HEIGHT + NUM_PADDING);
  localparam logic [15:0] c_COL_LASTK = 16'(IMG_WIDTH + NUM_PADDING - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic [15:0] col_q, col_d;
  logic [15:0] row_q, row_d;

  logic                m_valid_q, m_valid_d;
  logic [C_AXIS_TDATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [SW-1:0]       m_strb_q, m_strb_d;
  logic                m_last_q, m_last_d;
  logic                m_user_q, m_user_d;
  logic                err_line_q, err_line_d;
  logic                err_sof_q, err_sof_d;

  logic [15:0] w_col;
  logic [15:0] w_row;
  logic        w_proc;
  logic        w_keep;
  logic        w_acc;
  logic        w_col_end;
  logic        w_eol;
  logic        w_frame_end;

  // A tuser beat always counts as pixel (0,0), whether it opens a frame from
  // IDLE or restarts one mid-frame.
  always_comb begin
    w_col       = s00_axis_tuser ? 16'd0 : col_q;
    w_row       = s00_axis_tuser ? 16'd0 : row_q;
    w_proc      = (state_q == ST_ACTIVE) || s00_axis_tuser;
    w_keep      = w_proc &&
                  (w_col >= c_LO) && (w_col < c_COL_HI) &&
                  (w_row >= c_LO) && (w_row < c_ROW_HI);
    // Dropped beats bypass the output register, so they never stall.
    s00_axis_tready = !reset && (!w_keep || !m_valid_q || m00_axis_tready);
    w_acc       = s00_axis_tvalid && s00_axis_tready;
    w_col_end   = (w_col == c_PW_LAST);
    w_eol       = w_col_end || s00_axis_tlast;
    w_frame_end = w_eol && (w_row == c_PH_LAST);
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    err_line_d = 1'b0;
    err_sof_d  = 1'b0;

    if (w_acc && w_proc) begin
      err_line_d = (w_col_end != s00_axis_tlast);
      err_sof_d  = (state_q == ST_ACTIVE) && s00_axis_tuser &&
                   ((col_q != 16'd0) || (row_q != 16'd0));
      if (w_eol) begin
        col_d = 16'd0;
        if (w_frame_end) begin
          row_d   = 16'd0;
          state_d = ST_IDLE;
        end else begin
          row_d   = w_row + 16'd1;
          state_d = ST_ACTIVE;
        end
      end else begin
        col_d   = w_col + 16'd1;
        row_d   = w_row;
        state_d = ST_ACTIVE;
      end
    end
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_strb_d  = m_strb_q;
    m_last_d  = m_last_q;
    m_user_d  = m_user_q;

    if (w_acc && w_keep) begin
      m_valid_d = 1'b1;
      m_data_d  = s00_axis_tdata;
      m_strb_d  = s00_axis_tstrb;
      m_last_d  = (w_col == c_COL_LASTK);
      m_user_d  = (w_col == c_LO) && (w_row == c_LO);
    end else if (m00_axis_tready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      col_q      <= 16'd0;
      row_q      <= 16'd0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_strb_q   <= '0;
      m_last_q   <= 1'b0;
      m_user_q   <= 1'b0;
      err_line_q <= 1'b0;
      err_sof_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_strb_q   <= m_strb_d;
      m_last_q   <= m_last_d;
      m_user_q   <= m_user_d;
      err_line_q <= err_line_d;
      err_sof_q  <= err_sof_d;
    end
  end

  assign m00_axis_tvalid = m_valid_q;
  assign m00_axis_tdata  = m_data_q;
  assign m00_axis_tstrb  = m_strb_q;
  assign m00_axis_tlast  = m_last_q;
  assign m00_axis_tuser  = m_user_q;
  assign err_line        = err_line_q;
  assign err_sof         = err_sof_q;

endmodule

`default_nettype wire

// File: tb/tb_border_crop_axis.sv
// ============================================================================
// Module   : tb_border_crop_axis
// Purpose  : Self-checking bench for border_crop_axis (4x3 image, 1-pixel halo).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_border_crop_axis;

  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int P  = 1;
  localparam int PW = W + 2 * P;
  localparam int PH = H + 2 * P;

  typedef struct packed {
    logic          u;
    logic          l;
    logic [SW-1:0] s;
    logic [DW-1:0] d;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic [SW-1:0] s_strb = '0;
  logic          s_last = 1'b0;
  logic          s_user = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic [SW-1:0] m_strb;
  logic          m_last;
  logic          m_user;
  logic          err_line;
  logic          err_sof;

  always #5 clk = ~clk;

  border_crop_axis #(
    .C_AXIS_TDATA_WIDTH(DW),
    .IMG_WIDTH(W),
    .IMG_HEIGHT(H),
    .NUM_PADDING(P)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s00_axis_tvalid(s_valid),
    .s00_axis_tready(s_ready),
    .s00_axis_tdata(s_data),
    .s00_axis_tstrb(s_strb),
    .s00_axis_tlast(s_last),
    .s00_axis_tuser(s_user),
    .m00_axis_tvalid(m_valid),
    .m00_axis_tready(m_ready),
    .m00_axis_tdata(m_data),
    .m00_axis_tstrb(m_strb),
    .m00_axis_tlast(m_last),
    .m00_axis_tuser(m_user),
    .err_line(err_line),
    .err_sof(err_sof)
  );

  int    total = 0;
  int    bad = 0;
  int    rmode = 0;
  int    cyc = 0;
  beat_t stim[$];
  bit    keepf[$];
  beat_t exp_q[$];
  beat_t got_q[$];
  int    exp_el, exp_es;
  int    n_el = 0;
  int    n_es = 0;
  int    stall_viol = 0;
  beat_t held;
  bit    hold_v = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Downstream ready patterns: always, 1-0-0-1, random, never.
  initial forever begin
    @(posedge clk);
    #2;
    cyc++;
    case (rmode)
      0:       m_ready = 1'b1;
      1:       m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      2:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  initial forever begin
    beat_t cur;
    @(negedge clk);
    cur = {m_user, m_last, m_strb, m_data};
    if (m_valid && m_ready) got_q.push_back(cur);
    if (hold_v && m_valid) chk("hold_stable", 64'(cur), 64'(held));
    hold_v = m_valid && !m_ready;
    held   = cur;
    if (err_line) n_el++;
    if (err_sof) n_es++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic add_frame(input int base, input int erow, input int ecol,
                           input int nmax, input bit rnd);
    int n = 0;
    for (int r = 0; r < PH; r++) begin
      int nc = (r == erow) ? ecol + 1 : PW;
      for (int c = 0; c < nc; c++) begin
        beat_t b;
        if (n >= nmax) return;
        b.d = rnd ? $urandom : 32'(base + r * PW + c);
        b.s = 4'($urandom);
        b.l = (c == nc - 1);
        b.u = (r == 0 && c == 0);
        stim.push_back(b);
        n++;
      end
    end
  endtask

  task automatic add_garbage(input int n);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.d = $urandom;
      b.s = 4'($urandom);
      b.l = 1'($urandom_range(0, 1));
      b.u = 1'b0;
      stim.push_back(b);
    end
  endtask

  // Reference: walk the padded grid beat by beat and apply the crop rules.
  task automatic run_model();
    bit act = 0;
    int c = 0;
    int r = 0;
    exp_q.delete();
    keepf.delete();
    exp_el = 0;
    exp_es = 0;
    foreach (stim[i]) begin
      bit    k;
      beat_t o;
      if (!act && !stim[i].u) begin
        keepf.push_back(1'b0);
        continue;
      end
      if (stim[i].u) begin
        if (act && (c != 0 || r != 0)) exp_es++;
        c = 0;
        r = 0;
        act = 1;
      end
      k = (c >= P) && (c < P + W) && (r >= P) && (r < P + H);
      keepf.push_back(k);
      if (k) begin
        o.d = stim[i].d;
        o.s = stim[i].s;
        o.l = (c == P + W - 1);
        o.u = (c == P) && (r == P);
        exp_q.push_back(o);
      end
      if ((c == PW - 1) != stim[i].l) exp_el++;
      if (c == PW - 1 || stim[i].l) begin
        c = 0;
        r++;
        if (r == PH) begin
          act = 0;
          r = 0;
        end
      end else begin
        c++;
      end
    end
  endtask

  task automatic run_stim(input bit gaps);
    foreach (stim[i]) begin
      bit acc = 0;
      if (gaps) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      s_valid = 1'b1;
      s_data  = stim[i].d;
      s_strb  = stim[i].s;
      s_last  = stim[i].l;
      s_user  = stim[i].u;
      for (int n = 0; n < 1000 && !acc; n++) begin
        @(negedge clk);
        if (s_ready) acc = 1;
        else if (!keepf[i]) stall_viol++;
        @(posedge clk);
        #1;
      end
      if (!acc) begin
        chk("accept_timeout", 64'(acc), 64'(1));
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
    s_user  = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic run_case(input string name, input bit gaps);
    run_model();
    got_q.delete();
    n_el = 0;
    n_es = 0;
    stall_viol = 0;
    run_stim(gaps);
    for (int n = 0; n < 300 && got_q.size() < exp_q.size(); n++) @(negedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({name, "_beat"}, 64'(got_q[i]), 64'(exp_q[i]));
    chk({name, "_err_line"}, 64'(n_el), 64'(exp_el));
    chk({name, "_err_sof"}, 64'(n_es), 64'(exp_es));
    chk({name, "_drop_stall"}, 64'(stall_viol), 64'(0));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(s_ready), 64'(0));
    chk("rst_outputs", 64'({m_valid, m_user, m_last, m_strb, m_data}), 64'(0));
    chk("rst_err", 64'({err_line, err_sof}), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", 64'(s_ready), 64'(1));
    @(posedge clk);
    #1;

    stim.delete();
    add_frame(0, -1, 0, 1000, 0);
    run_case("nominal", 0);
    chk("nominal_first", 64'(exp_q.size() > 0 ? exp_q[0].d : 0), 64'(7));

    rmode = 1;
    run_case("backpressure", 0);
    rmode = 0;

    stim.delete();
    add_garbage(3);
    add_frame(0, -1, 0, 1000, 0);
    run_case("garbage", 1);

    stim.delete();
    add_frame(0, 2, 2, 1000, 0);
    run_case("early_tlast", 0);

    stim.delete();
    add_frame(0, -1, 0, 15, 0);
    add_frame(100, -1, 0, 1000, 0);
    run_case("mid_sof", 1);

    rmode = 2;
    stim.delete();
    add_garbage(2);
    add_frame(0, -1, 0, 1000, 1);
    add_frame(0, -1, 0, 1000, 1);
    run_case("random", 1);

    // Reset while beat 10 sits un-consumed in the output register.
    rmode = 0;
    repeat (2) @(posedge clk);
    #1;
    stim.delete();
    add_frame(0, -1, 0, 11, 0);
    run_model();
    got_q.delete();
    run_stim(0);
    rmode = 3;
    @(negedge clk);
    chk("held_before_reset", 64'({m_valid, m_data}), {31'd0, 1'b1, 32'd10});
    chk("consumed_before_reset", 64'(got_q.size()), 64'(3));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("ready_in_reset", 64'(s_ready), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("valid_after_reset", 64'(m_valid), 64'(0));
    rmode = 0;
    @(posedge clk);
    #1;
    stim.delete();
    add_frame(200, -1, 0, 1000, 0);
    run_case("after_reset", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
